// File: rtl/acc16_seq.sv
// rtl/acc16_seq.sv - sequential 16-bit accumulator driving an external adder
//
// Purpose: sums a stream of 16-bit operands using an external combinational
// adder, then presents the final sum and the adder flags of the last add.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a new run (honoured in IDLE only)
//   op_valid/op_data/op_last/op_ready   operand stream
//   add_a/add_b/add_cin    operands presented to the external adder
//   add_out, add_zero, add_carry, add_sign, add_parity, add_overflow
//                          result and flags returned by the external adder
//   res_valid/res_ready/res_data/res_flags   result stream,
//                          res_flags = {zero,carry,sign,parity,overflow}
//   sticky_ovf             OR of add_overflow over every add of the run
//   busy                   high whenever the FSM is not in IDLE

module acc16_seq #(
    parameter bit CHAIN_CARRY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_valid,
    input  logic [15:0] op_data,
    input  logic        op_last,
    output logic        op_ready,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_out,
    input  logic        add_zero,
    input  logic        add_carry,
    input  logic        add_sign,
    input  logic        add_parity,
    input  logic        add_overflow,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [4:0]  res_flags,
    output logic        sticky_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        pc_q, pc_d;
    logic        last_q, last_d;
    logic [15:0] add_a_q, add_a_d;
    logic [15:0] add_b_q, add_b_d;
    logic        add_cin_q, add_cin_d;
    logic [4:0]  flags_q, flags_d;
    logic        sticky_q, sticky_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= 16'h0000;
            pc_q      <= 1'b0;
            last_q    <= 1'b0;
            add_a_q   <= 16'h0000;
            add_b_q   <= 16'h0000;
            add_cin_q <= 1'b0;
            flags_q   <= 5'b00000;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pc_q      <= pc_d;
            last_q    <= last_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            flags_q   <= flags_d;
            sticky_q  <= sticky_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pc_d      = pc_q;
        last_d    = last_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        flags_d   = flags_q;
        sticky_d  = sticky_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = 16'h0000;
                    pc_d     = 1'b0;
                    sticky_d = 1'b0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                // Adder inputs are registered here and then held until the
                // next acceptance, so the external adder sees stable operands.
                if (op_valid) begin
                    add_a_d   = acc_q;
                    add_b_d   = op_data;
                    add_cin_d = CHAIN_CARRY ? pc_q : 1'b0;
                    last_d    = op_last;
                    state_d   = CAPT;
                end
            end
            CAPT: begin
                acc_d    = add_out;
                flags_d  = {add_zero, add_carry, add_sign, add_parity, add_overflow};
                pc_d     = add_carry;
                sticky_d = sticky_q | add_overflow;
                state_d  = last_q ? DONE : ACCUM;
            end
            DONE: begin
                // start is deliberately not looked at here; only res_ready acts.
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_ready   = (state_q == ACCUM);
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_cin    = add_cin_q;
    assign res_data   = acc_q;
    assign res_flags  = flags_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_acc16_seq.sv
// tb/tb_acc16_seq.sv - scoreboard bench for acc16_seq (both carry modes)

module tb_acc16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_valid = 1'b0;
    logic [15:0] op_data = 16'h0000;
    logic        op_last = 1'b0;
    logic        res_ready = 1'b1;

    // dut0: CHAIN_CARRY=0, dut1: CHAIN_CARRY=1; both share the stimulus.
    logic        op_ready0, op_ready1;
    logic [15:0] add_a0, add_a1, add_b0, add_b1;
    logic        add_cin0, add_cin1;
    logic [15:0] add_out0, add_out1;
    logic [4:0]  af0, af1;
    logic        res_valid0, res_valid1;
    logic [15:0] res_data0, res_data1;
    logic [4:0]  res_flags0, res_flags1;
    logic        sticky0, sticky1;
    logic        busy0, busy1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [21:0] q0[$];
    logic [21:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External adder model: {zero,carry,sign,parity,overflow} and sum.
    function automatic logic [20:0] adder(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
        logic [16:0] s;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
        ovf = (a[15] == b[15]) && (s[15] != a[15]);
        return {(s[15:0] == 16'h0000), s[16], s[15], ^s[15:0], ovf, s[15:0]};
    endfunction

    always_comb {af0, add_out0} = adder(add_a0, add_b0, add_cin0);
    always_comb {af1, add_out1} = adder(add_a1, add_b1, add_cin1);

    acc16_seq #(.CHAIN_CARRY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_valid(op_valid), .op_data(op_data), .op_last(op_last), .op_ready(op_ready0),
        .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
        .add_out(add_out0), .add_zero(af0[4]), .add_carry(af0[3]), .add_sign(af0[2]),
        .add_parity(af0[1]), .add_overflow(af0[0]),
        .res_valid(res_valid0), .res_ready(res_ready), .res_data(res_data0),
        .res_flags(res_flags0), .sticky_ovf(sticky0), .busy(busy0)
    );

    acc16_seq #(.CHAIN_CARRY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_valid(op_valid), .op_data(op_data), .op_last(op_last), .op_ready(op_ready1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_out(add_out1), .add_zero(af1[4]), .add_carry(af1[3]), .add_sign(af1[2]),
        .add_parity(af1[1]), .add_overflow(af1[0]),
        .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
        .res_flags(res_flags1), .sticky_ovf(sticky1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: pops an expected {data,flags,sticky} per handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid0 && res_ready) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0 unexpected result: got %h expected none", res_data0);
            end else begin
                chk("dut0 result", {42'd0, res_data0, res_flags0, sticky0}, {42'd0, q0.pop_front()});
            end
        end
        if (rst_n && res_valid1 && res_ready) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1 unexpected result: got %h expected none", res_data1);
            end else begin
                chk("dut1 result", {42'd0, res_data1, res_flags1, sticky1}, {42'd0, q1.pop_front()});
            end
        end
    end

    function automatic logic [63:0] outs0();
        return {6'd0, op_ready0, add_a0, add_b0, add_cin0, res_valid0, res_data0,
                res_flags0, sticky0, busy0};
    endfunction
    function automatic logic [63:0] outs1();
        return {6'd0, op_ready1, add_a1, add_b1, add_cin1, res_valid1, res_data1,
                res_flags1, sticky1, busy1};
    endfunction

    task automatic expect_res(input logic [15:0] d0, input logic [4:0] f0, input logic s0,
                              input logic [15:0] d1, input logic [4:0] f1, input logic s1);
        q0.push_back({d0, f0, s0});
        q1.push_back({d1, f1, s1});
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy after start", {62'd0, busy0, busy1}, 64'd3);
    endtask

    // Offers one operand, checks the registered adder inputs and, for the
    // last operand, that res_valid rises exactly two cycles after acceptance.
    task automatic send_op(input logic [15:0] d, input logic last, input logic cin1);
        bit got = 1'b0;
        op_valid = 1'b1; op_data = d; op_last = last;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (op_ready0 && op_ready1) begin got = 1'b1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL op_ready timeout: got %b%b expected 11", op_ready0, op_ready1);
            op_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op_last = 1'b0;
        chk("add_b", {32'd0, add_b0, add_b1}, {32'd0, d, d});
        chk("add_cin", {62'd0, add_cin0, add_cin1}, {62'd0, 1'b0, cin1});
        if (last) begin
            @(negedge clk);
            chk("res_valid at n+1", {62'd0, res_valid0, res_valid1}, 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("res_valid at n+2", {62'd0, res_valid0, res_valid1}, 64'd3);
            @(posedge clk); #1;
        end
    endtask

    logic [15:0] ops[3]  = '{16'h1111, 16'h2222, 16'h3333};
    logic [15:0] pref[3] = '{16'h0000, 16'h1111, 16'h3333};

    initial begin
        // Reset state
        #3;
        chk("reset outputs dut0", outs0(), 64'd0);
        chk("reset outputs dut1", outs1(), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle waits for start", {62'd0, busy0, busy1}, 64'd0);

        // Two-operand run: 0xA6C3 + 0xA22E
        expect_res(16'h48F1, 5'b01011, 1'b1, 16'h48F1, 5'b01011, 1'b1);
        start_run();
        send_op(16'hA6C3, 1'b0, 1'b0);
        send_op(16'hA22E, 1'b1, 1'b0);
        chk("idle after result", {62'd0, busy0, busy1}, 64'd0);

        // Chained carry: third add gets cin=1 only in dut1
        expect_res(16'h48F2, 5'b00010, 1'b1, 16'h48F3, 5'b00000, 1'b1);
        start_run();
        send_op(16'hA6C3, 1'b0, 1'b0);
        send_op(16'hA22E, 1'b0, 1'b0);
        send_op(16'h0001, 1'b1, 1'b1);

        // Single zero operand
        expect_res(16'h0000, 5'b10000, 1'b0, 16'h0000, 5'b10000, 1'b0);
        start_run();
        send_op(16'h0000, 1'b1, 1'b0);

        // Back-pressure in DONE with start pulses, then start+res_ready together
        res_ready = 1'b0;
        expect_res(16'h48F1, 5'b01011, 1'b1, 16'h48F1, 5'b01011, 1'b1);
        start_run();
        send_op(16'hA6C3, 1'b0, 1'b0);
        send_op(16'hA22E, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            @(negedge clk);
            chk("stall hold dut1",
                {40'd0, res_valid1, op_ready1, res_data1, res_flags1, 1'b0},
                {40'd0, 1'b1, 1'b0, 16'h48F1, 5'b01011, 1'b0});
            chk("stall hold dut0",
                {40'd0, res_valid0, op_ready0, res_data0, res_flags0, 1'b0},
                {40'd0, 1'b1, 1'b0, 16'h48F1, 5'b01011, 1'b0});
            @(posedge clk); #1;
        end
        start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle after start+res_ready", {62'd0, busy0, busy1}, 64'd0);
        @(posedge clk); #1;

        // Continuous op_valid: one acceptance every 2 cycles
        expect_res(16'h6666, 5'b00000, 1'b0, 16'h6666, 5'b00000, 1'b0);
        start_run();
        begin
            int k = 0;
            op_valid = 1'b1; op_data = ops[0]; op_last = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("op_ready toggle", {62'd0, op_ready0, op_ready1},
                    (i % 2 == 0) ? 64'd3 : 64'd0);
                if (i % 2 == 1)
                    chk("add_a tracks acc", {32'd0, add_a0, add_a1},
                        {32'd0, pref[(i-1)/2], pref[(i-1)/2]});
                @(posedge clk); #1;
                if (i % 2 == 0 && k < 2) begin
                    k++;
                    op_data = ops[k];
                    op_last = (k == 2);
                end
            end
            op_valid = 1'b0; op_last = 1'b0;
            repeat (2) @(posedge clk);
            #1 chk("idle after continuous", {62'd0, busy0, busy1}, 64'd0);
        end

        // Reset while in CAPT aborts the run
        start_run();
        send_op(16'h1234, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort outputs dut0", outs0(), 64'd0);
        chk("abort outputs dut1", outs1(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle after abort", {62'd0, busy0, busy1}, 64'd0);
        expect_res(16'h38F1, 5'b00000, 1'b0, 16'h38F1, 5'b00000, 1'b0);
        start_run();
        send_op(16'h36C3, 1'b0, 1'b0);
        send_op(16'h022E, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", {32'd0, q0.size(), q1.size()}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/acc16_seq.md
ACC16_SEQ -- requirements
Module: acc16_seq

Interface
REQ-001 The block SHALL have parameter CHAIN_CARRY, default 0; when 1, each add uses the previous add's carry-out as carry-in.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a new accumulation; honoured only in IDLE.
REQ-005 The block SHALL have ports op_valid (input, 1), op_data (input, 16), op_last (input, 1) and op_ready (output, 1) forming the operand stream.
REQ-006 The block SHALL have ports add_a (output, 16), add_b (output, 16) and add_cin (output, 1), which drive the external 16-bit adder.
REQ-007 The block SHALL have ports add_out (input, 16) and add_zero, add_carry, add_sign, add_parity, add_overflow (inputs, 1 each), which return the adder result and flags.
REQ-008 The block SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 16) and res_flags (output, 5, {zero,carry,sign,parity,overflow}) forming the result stream.
REQ-009 The block SHALL have ports sticky_ovf (output, 1), the OR of add_overflow over all adds in the run, and busy (output, 1), high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have four states: IDLE, ACCUM, CAPT and DONE.
REQ-011 In IDLE, start=1 SHALL clear acc, the previous-carry bit (pc) and sticky_ovf, and move the FSM to ACCUM.
REQ-012 op_ready SHALL be 1 only in ACCUM.
REQ-013 On an op_valid&op_ready cycle, the block SHALL register add_a=acc, add_b=op_data, add_cin=(CHAIN_CARRY ? pc : 0) and last_q=op_last, and move to CAPT.
REQ-014 add_a, add_b and add_cin SHALL remain stable from the cycle after acceptance until the next operand is accepted.
REQ-015 In CAPT, the block SHALL set acc<=add_out, flags<=adder flags, pc<=add_carry and sticky_ovf<=sticky_ovf|add_overflow, then move to DONE if last_q=1, else to ACCUM.
REQ-016 Throughput SHALL be at most one operand per 2 cycles, since op_ready is low in CAPT.
REQ-017 If the last operand is accepted in cycle n, res_valid SHALL be 1 from cycle n+2.
REQ-018 In DONE, res_valid=1; res_data=acc and res_flags SHALL hold stable until res_valid&res_ready, then the FSM returns to IDLE in the next cycle.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 op_valid outside ACCUM SHALL be ignored and no operand consumed.
REQ-021 A run SHALL always contain at least one operand; there is no empty-run result.
REQ-022 Addition SHALL wrap modulo 2^16; the carry-out is reported only via the flags and pc.
REQ-023 The flags SHALL be passed through from the adder unmodified; the block computes no flag itself.
REQ-024 start and res_ready asserted together in DONE: only res_ready SHALL act; start is ignored.

Reset
REQ-025 On rst_n=0, regardless of clk: state=IDLE; acc, pc, last_q, add_a, add_b, add_cin, res_data, res_flags and sticky_ovf SHALL be 0; op_ready, res_valid and busy SHALL be 0.
REQ-026 Reset asserted mid-run (any state) SHALL abort the run with no result emitted.
REQ-027 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-028 CHAIN_CARRY=0; start; operands 0xA6C3, then 0xA22E with last -> res_data=0x48F1, carry=1, overflow=1, sign=0, zero=0, sticky_ovf=1.
REQ-029 CHAIN_CARRY=1; operands 0xA6C3, 0xA22E, then 0x0001 with last -> third add has add_cin=1; res_data=0x48F3, carry=0, overflow=0, sticky_ovf=1.
REQ-030 Single operand 0x0000 with last -> res_data=0x0000, zero=1, all other flags 0, res_valid exactly 2 cycles after acceptance.
REQ-031 res_ready held 0 for 5 cycles in DONE -> res_valid, res_data and res_flags stable; op_ready=0; start pulses ignored; res_ready=1 -> IDLE next cycle.
REQ-032 op_valid held high continuously -> op_ready toggles 1,0,1,0; exactly one acceptance per 2 cycles; add_a tracks the running acc.
REQ-033 rst_n pulsed low while in CAPT -> all outputs 0 immediately; after release, a new run computes 0x36C3+0x022E=0x38F1 correctly.
